// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the init/run state encoding and a packed-slice extractor used by the read ports.
package reg_file_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SLICE_VEC_W = 256;
    localparam int SLICE_W     = 64;

    // Returns field idx of width w from a packed vector; callers truncate to their width.
    function automatic logic [SLICE_W-1:0] get_slice(
        input logic [SLICE_VEC_W-1:0] vec,
        input int                     idx,
        input int                     w
    );
        logic [SLICE_VEC_W-1:0] shifted;
        shifted = vec >> (idx * w);
        return shifted[SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Read/write/scoreboard bus between the datapath (master) and the register file (slave).
// Purely wiring; no storage.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy_set;
    logic [ADDR_W-1:0]        busy_addr;
    logic                     ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits tracking outstanding producers; set beats clear on the same entry.
// Latency: lookups are combinational on the pre-edge state; no backpressure.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
    output logic [NUM_RD-1:0]        lk_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // Clear first so a new producer on the same entry overrides the retiring write.
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        a       = '0;
        lk_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a          = ADDR_W'(get_slice(SLICE_VEC_W'(lk_addr), i, ADDR_W));
            lk_busy[i] = busy_q[a];
        end
    end
endmodule

// File: rtl/reg_file_param.sv
// Parametrised multi-port register file with zeroing sweep, write bypass and busy scoreboard.
// Latency: reads 0 or 1 cycle (READ_REG); no backpressure, writes/busy sets dropped until ready.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_file_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    state_t                        state;
    logic [ADDR_W-1:0]             ptr;
    logic                          ready_q;
    logic [DATA_W-1:0]             mem [DEPTH];
    logic                          wr_acc;
    logic [NUM_RD-1:0][DATA_W-1:0] sel;
    logic [NUM_RD-1:0]             lk_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            ptr     <= '0;
            ready_q <= 1'b0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == ADDR_W'(DEPTH - 1)) begin
                state   <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign wr_acc = ready_q && bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // The array has no reset; the sweep owns the write port until ready.
    always_ff @(posedge clk) begin
        if (!ready_q)    mem[ptr]         <= '0;
        else if (wr_acc) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra  = '0;
        sel = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = ADDR_W'(get_slice(SLICE_VEC_W'(bus.rd_addr), i, ADDR_W));
            if (ready_q) begin
                sel[i] = mem[ra];
                if ((BYPASS != 0) && wr_acc && (bus.wr_addr == ra)) sel[i] = bus.wr_data;
                if ((ZERO_REG != 0) && (ra == '0))                   sel[i] = '0;
            end
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [NUM_RD-1:0][DATA_W-1:0] rd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= '0;
            else        rd_q <= sel;
        end
        assign bus.rd_data = rd_q;
    end else begin : g_rd_comb
        assign bus.rd_data = sel;
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (bus.busy_set && ready_q),
        .set_addr (bus.busy_addr),
        .clr_en   (wr_acc),
        .clr_addr (bus.wr_addr),
        .lk_addr  (bus.rd_addr),
        .lk_busy  (lk_busy)
    );

    assign bus.rd_busy = lk_busy & {NUM_RD{ready_q}};
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Two instances: A = zero reg + bypass + comb read; B = no zero reg, no bypass, registered read.
module tb_reg_file_param;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_a ();
    reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_b ();

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                     .ZERO_REG(1), .BYPASS(1), .READ_REG(0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                     .ZERO_REG(0), .BYPASS(0), .READ_REG(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd0, rd1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        bs;
        logic [4:0]  ba;
        logic [31:0] a0, a1;
        logic [1:0]  ab;
        logic [31:0] b0, b1;
        logic [1:0]  bb;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(
        input logic [4:0] rd0, input logic [4:0] rd1,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic bs, input logic [4:0] ba,
        input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] ab,
        input logic [31:0] b0, input logic [31:0] b1, input logic [1:0] bb
    );
        vec_t v;
        v.rd0 = rd0; v.rd1 = rd1; v.we = we; v.wa = wa; v.wd = wd;
        v.bs = bs; v.ba = ba; v.a0 = a0; v.a1 = a1; v.ab = ab;
        v.b0 = b0; v.b1 = b1; v.bb = bb;
        return v;
    endfunction

    task automatic drive(input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic bs, input logic [4:0] ba);
        if_a.rd_addr = {rd1, rd0};  if_b.rd_addr = {rd1, rd0};
        if_a.wr_en = we;            if_b.wr_en = we;
        if_a.wr_addr = wa;          if_b.wr_addr = wa;
        if_a.wr_data = wd;          if_b.wr_data = wd;
        if_a.busy_set = bs;         if_b.busy_set = bs;
        if_a.busy_addr = ba;        if_b.busy_addr = ba;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int  cnt;
        bit  bad;
        n_checks = 0;
        n_err    = 0;

        // Expectations for B are what its output register shows during the vector,
        // i.e. the selection captured at the previous edge (no bypass, no zero reg).
        tbl[0]  = mk(0, 0, 1, 2, 32'hF0,       0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        2'b00);
        tbl[1]  = mk(2, 4, 1, 4, 32'h0F,       0, 0, 32'hF0,       32'h0F,       2'b00, 32'h0,        32'h0,        2'b00);
        tbl[2]  = mk(2, 4, 0, 0, 32'h0,        0, 0, 32'hF0,       32'h0F,       2'b00, 32'hF0,       32'h0,        2'b00);
        tbl[3]  = mk(7, 4, 1, 7, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0F,       2'b00, 32'hF0,       32'h0F,       2'b00);
        tbl[4]  = mk(7, 7, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0,        32'h0F,       2'b00);
        tbl[5]  = mk(0, 7, 1, 0, 32'h12345678, 1, 0, 32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        2'b00, 32'h0,        32'hDEADBEEF, 2'b11);
        tbl[7]  = mk(5, 0, 0, 0, 32'h0,        1, 5, 32'h0,        32'h0,        2'b00, 32'h12345678, 32'h12345678, 2'b10);
        tbl[8]  = mk(5, 5, 1, 5, 32'h55,       0, 0, 32'h55,       32'h55,       2'b11, 32'h0,        32'h12345678, 2'b11);
        tbl[9]  = mk(5, 5, 0, 0, 32'h0,        0, 0, 32'h55,       32'h55,       2'b00, 32'h0,        32'h0,        2'b00);
        tbl[10] = mk(5, 4, 1, 5, 32'h66,       1, 5, 32'h66,       32'h0F,       2'b00, 32'h55,       32'h55,       2'b00);
        tbl[11] = mk(5, 4, 0, 0, 32'h0,        0, 0, 32'h66,       32'h0F,       2'b01, 32'h55,       32'h0F,       2'b01);
        tbl[12] = mk(5, 3, 1, 5, 32'h77,       1, 3, 32'h77,       32'h0,        2'b01, 32'h66,       32'h0F,       2'b01);
        tbl[13] = mk(5, 3, 0, 0, 32'h0,        0, 0, 32'h77,       32'h0,        2'b10, 32'h66,       32'h0,        2'b10);
        tbl[14] = mk(2, 4, 0, 0, 32'h0,        0, 0, 32'hF0,       32'h0F,       2'b00, 32'h77,       32'h0,        2'b00);
        tbl[15] = mk(2, 4, 0, 0, 32'h0,        0, 0, 32'hF0,       32'h0F,       2'b00, 32'hF0,       32'h0F,       2'b00);

        // Reset with writes/busy sets pending that the sweep must ignore.
        rst_n = 1'b0;
        drive(2, 3, 1, 2, 32'h55, 1, 3);
        repeat (2) @(posedge clk);
        #1;
        check("rst ready_a", 32'(if_a.ready), 32'h0);
        check("rst ready_b", 32'(if_b.ready), 32'h0);
        check("rst b_d0", if_b.rd_data[31:0], 32'h0);
        check("rst b_d1", if_b.rd_data[63:32], 32'h0);
        check("rst busy_a", 32'(if_a.rd_busy), 32'h0);

        rst_n = 1'b1;
        cnt = 0;
        bad = 1'b0;
        while (!if_a.ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!if_a.ready && (if_a.rd_data != '0 || if_b.rd_data != '0 ||
                                if_a.rd_busy != '0 || if_b.rd_busy != '0))
                bad = 1'b1;
        end
        drive(2, 3, 0, 0, 32'h0, 0, 0);
        check("sweep cycles", 32'(cnt), 32'd32);
        check("sweep ready_b", 32'(if_b.ready), 32'h1);
        check("sweep reads zero", 32'(bad), 32'h0);
        #1;
        check("sweep wr ignored a", if_a.rd_data[31:0], 32'h0);
        check("sweep busy ignored a", 32'(if_a.rd_busy), 32'h0);
        @(posedge clk);
        #1;
        check("sweep wr ignored b", if_b.rd_data[31:0], 32'h0);
        check("sweep busy ignored b", 32'(if_b.rd_busy), 32'h0);

        drive(0, 0, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rd0, tbl[i].rd1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].bs, tbl[i].ba);
            #1;
            check($sformatf("v%0d a_d0", i), if_a.rd_data[31:0],  tbl[i].a0);
            check($sformatf("v%0d a_d1", i), if_a.rd_data[63:32], tbl[i].a1);
            check($sformatf("v%0d a_busy", i), 32'(if_a.rd_busy), 32'(tbl[i].ab));
            check($sformatf("v%0d b_d0", i), if_b.rd_data[31:0],  tbl[i].b0);
            check($sformatf("v%0d b_d1", i), if_b.rd_data[63:32], tbl[i].b1);
            check($sformatf("v%0d b_busy", i), 32'(if_b.rd_busy), 32'(tbl[i].bb));
            @(posedge clk);
            #1;
        end

        // Reset while running, then again mid-sweep at ptr=10.
        drive(7, 3, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst2 b_d0 async", if_b.rd_data[31:0], 32'h0);
        check("rst2 ready_a", 32'(if_a.ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("resweep a_d0 gated", if_a.rd_data[31:0], 32'h0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midsweep ready_a", 32'(if_a.ready), 32'h0);
        rst_n = 1'b1;
        cnt = 0;
        while (!if_a.ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("restart sweep cycles", 32'(cnt), 32'd32);
        check("restart a_d0 r7", if_a.rd_data[31:0], 32'h0);
        check("restart a_busy r3", 32'(if_a.rd_busy), 32'h0);
        @(posedge clk);
        #1;
        check("restart b_d0 r7", if_b.rd_data[31:0], 32'h0);
        check("restart b_busy r3", 32'(if_b.rd_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
